si_inst_sequencer: RTL
======================

# si_inst_sequencer

Sequences the symbolic instruction stream into the RIDECORE fetch port for symbolic-initial-state checking. It takes a free, externally constrained 32-bit instruction each cycle and registers it toward the core under a valid/stall handshake. It treats the all-ones-opcode NOP as a fetch bubble and counts issued instructions up to a bound. After the bound, it drains the pipeline with bubbles for a fixed window, then pulses the enable for the equivalence/isolation check.

## Interface
- `N_INST`, default 8: number of non-NOP instructions to issue; legal range 1..2^CNT_W-1.
- `DRAIN_CYCLES`, default 16: bubble cycles between the last issue and the check; legal range ≥1.
- `CNT_W`, default 8: width of the issue and drain counters.

Ports:
- `clk`  in  1  — sole clock, rising edge.
- `reset_x`  in  1  — reset, asynchronous, active-low.
- `start`  in  1  — begin a run; sampled only in IDLE.
- `inst_in`  in  32  — free symbolic instruction, already constrained to the allowed ISA subset.
- `stall`  in  1  — core fetch cannot accept this cycle.
- `inst_out`  out  32  — registered instruction to fetch.
- `inst_valid`  out  1  — `inst_out` is a real instruction.
- `issued_cnt`  out  CNT_W  — accepted instructions this run.
- `busy`  out  1  — state is FEED or DRAIN.
- `check_en`  out  1  — one-cycle pulse that enables the check.
- `done`  out  1  — sticky run-complete flag.

## Operation
- NOP is opcode `7'b1111111`. `NOP_INST` = 32'h0000_007F.
- The state machine has five states: IDLE, FEED, DRAIN, CHECK, DONE.
- IDLE:
  - Outputs: `inst_valid`=0, `inst_out`=NOP_INST.
  - `start`=1 moves to FEED and clears `issued_cnt`.
- FEED:
  - An issue is accepted when `inst_valid`=1 and `stall`=0; `issued_cnt` increments on acceptance.
  - The output register loads when `inst_valid`=0 or `stall`=0. When `inst_valid`=1 and `stall`=1, `inst_out`/`inst_valid` hold unchanged, whatever `inst_in` is.
  - On a load, let `next_cnt` = `issued_cnt` + accept:
    - If `inst_in` is non-NOP and `next_cnt` < N_INST, capture it with `inst_valid`=1.
    - Otherwise load NOP_INST with `inst_valid`=0; the bubble is not counted.
  - Leave for DRAIN in the cycle whose acceptance makes `issued_cnt` reach N_INST.
- DRAIN:
  - Outputs: `inst_valid`=0, `inst_out`=NOP_INST.
  - The drain counter counts DRAIN_CYCLES cycles, ignoring `stall`, then moves to CHECK.
- CHECK: `check_en`=1 for one cycle, then DONE.
- DONE:
  - `done`=1.
  - Holds until reset; `start` is ignored.
- `start` outside IDLE is ignored.
- Counters never wrap; `issued_cnt` saturates at N_INST by construction.

## Timing
- Reset, async on `reset_x`=0, including mid-run:
  - State returns to IDLE.
  - `inst_out`=NOP_INST.
  - `inst_valid`, `issued_cnt`, `check_en`, `done` and `busy` are all 0.
  - Drain counter is 0.
- `start` high in cycle t:
  - FEED in t+1.
  - First capture at the end of t+1, so `inst_valid` can first be high in t+2.
- Capture latency `inst_in`→`inst_out` is one cycle when not stalled.
- Last acceptance in cycle a:
  - DRAIN spans a+1 through a+DRAIN_CYCLES.
  - `check_en` is high in a+DRAIN_CYCLES+1.
  - `done` is high from a+DRAIN_CYCLES+2.
- Simultaneous accept and load in the same cycle: the new instruction replaces the accepted one, giving back-to-back issue at one per cycle.
- `check_en` and `done` are registered, not combinational from inputs.

## Structure
- Package `si_seq_pkg` holds:
  - the state enum `si_seq_state_t`;
  - `OPC_NOP` = 7'b1111111;
  - `NOP_INST`;
  - an `is_nop()` function.
- One sub-module, `si_issue_reg`: the 32-bit output register with hold-on-stall and bubble load.
- The FSM and both counters stay in the top module.

## Test plan
- **Reset values:** `reset_x`=0 → all outputs at reset values; deassert with `start`=0 → stays IDLE indefinitely.
- **No stall:** N_INST=4, DRAIN_CYCLES=3, `start` at t=0, 4 non-NOP instructions, `stall`=0 → `inst_valid` in cycles 2–5, `issued_cnt`=4 at cycle 6, `check_en` in cycle 9 only, `done` from cycle 10.
- **Stall hold:** `stall`=1 for 3 cycles while `inst_valid`=1 with `inst_out`=32'h00208033 (ADD) → `inst_out` holds 32'h00208033 through the stall despite changing `inst_in`; `issued_cnt` unchanged until `stall` drops.
- **NOP bubbles:** `inst_in`=NOP_INST for 2 cycles mid-FEED → `inst_valid`=0 for 2 cycles; `issued_cnt` not incremented; the run extends by 2 cycles.
- **Reset mid-run:** `reset_x` pulsed low during DRAIN → IDLE immediately, `busy`=0, `check_en` never fires.
- **Start ignored, N_INST=1:**
  - `start` pulsed during FEED and during DONE → no effect.
  - N_INST=1: exactly one issue, and `inst_valid` never reasserts after the acceptance.

Source files
------------

// File: rtl/si_seq_pkg.sv
// Shared types and constants for the symbolic instruction sequencer.
package si_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FEED  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } si_seq_state_t;

   localparam logic [6:0]  OPC_NOP  = 7'b1111111;
   localparam logic [31:0] NOP_INST = 32'h0000_007F;

   // Any instruction carrying the all-ones opcode is a fetch bubble.
   function automatic logic is_nop(input logic [6:0] opcode);
      return opcode == OPC_NOP;
   endfunction

endpackage

// File: rtl/si_inst_sequencer_issue_reg.sv
// Output register toward the fetch port: holds while stalled, loads a
// captured instruction or a NOP bubble otherwise.
module si_issue_reg
   import si_seq_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        load_i,
   input  logic        capture_i,
   input  logic [31:0] inst_i,
   output logic [31:0] inst_o,
   output logic        valid_o
);

   logic [31:0] inst_q, inst_d;
   logic        valid_q, valid_d;

   // Flush wins (outside FEED the port always shows a bubble); otherwise a
   // load either captures the input or inserts an uncounted bubble.
   always_comb begin
      inst_d  = inst_q;
      valid_d = valid_q;
      if (flush_i) begin
         inst_d  = NOP_INST;
         valid_d = 1'b0;
      end else if (load_i) begin
         inst_d  = capture_i ? inst_i : NOP_INST;
         valid_d = capture_i;
      end
   end

   // Output register state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inst_q  <= NOP_INST;
         valid_q <= 1'b0;
      end else begin
         inst_q  <= inst_d;
         valid_q <= valid_d;
      end
   end

   assign inst_o  = inst_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/si_inst_sequencer.sv
// Feeds a bounded stream of symbolic instructions into the core fetch port,
// drains with bubbles, then pulses the check enable once.
module si_inst_sequencer
   import si_seq_pkg::*;
#(
   parameter int N_INST       = 8,
   parameter int DRAIN_CYCLES = 16,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             reset_x,
   input  logic             start,
   input  logic [31:0]      inst_in,
   input  logic             stall,
   output logic [31:0]      inst_out,
   output logic             inst_valid,
   output logic [CNT_W-1:0] issued_cnt,
   output logic             busy,
   output logic             check_en,
   output logic             done
);

   localparam logic [CNT_W-1:0] N_LIM      = CNT_W'(N_INST);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

   si_seq_state_t    state_q, state_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] drain_q, drain_d;
   logic [CNT_W-1:0] next_cnt;
   logic             check_q, check_d;
   logic             done_q, done_d;
   logic             accept, load_en, capture, flush;
   logic             valid_w;
   logic [31:0]      inst_w;

   // Handshake: accept and reload share a cycle so issue runs one per clock.
   // Capture is refused once this accept reaches the bound, so the last
   // accepted instruction is followed only by bubbles.
   always_comb begin
      accept   = (state_q == ST_FEED) && valid_w && !stall;
      next_cnt = issued_q + {{(CNT_W-1){1'b0}}, accept};
      load_en  = (state_q == ST_FEED) && (!valid_w || !stall);
      capture  = !is_nop(inst_in[6:0]) && (next_cnt < N_LIM);
      flush    = (state_q != ST_FEED);
   end

   si_issue_reg u_issue (
      .clk_i     (clk),
      .rst_ni    (reset_x),
      .flush_i   (flush),
      .load_i    (load_en),
      .capture_i (capture),
      .inst_i    (inst_in),
      .inst_o    (inst_w),
      .valid_o   (valid_w)
   );

   // Run sequencing plus issue and drain counters.
   always_comb begin
      state_d  = state_q;
      issued_d = issued_q;
      drain_d  = drain_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_FEED;
               issued_d = '0;
            end
         end
         ST_FEED: begin
            issued_d = next_cnt;
            if (accept && (next_cnt == N_LIM)) begin
               state_d = ST_DRAIN;
               drain_d = '0;
            end
         end
         ST_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               state_d = ST_CHECK;
               drain_d = '0;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         ST_CHECK: state_d = ST_DONE;
         ST_DONE:  state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
      check_d = (state_d == ST_CHECK);
      done_d  = (state_d == ST_DONE);
   end

   // Sequencer state; check_en and done come straight from flops.
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         state_q  <= ST_IDLE;
         issued_q <= '0;
         drain_q  <= '0;
         check_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         issued_q <= issued_d;
         drain_q  <= drain_d;
         check_q  <= check_d;
         done_q   <= done_d;
      end
   end

   assign inst_out   = inst_w;
   assign inst_valid = valid_w;
   assign issued_cnt = issued_q;
   assign busy       = (state_q == ST_FEED) || (state_q == ST_DRAIN);
   assign check_en   = check_q;
   assign done       = done_q;

endmodule
